// File: rtl/fir_out_frame_buf_if.sv
// fir_out_frame_buf_if: FIR sample input and framed output stream bundle
//   din_valid/din           FIR sample stream into the buffer (no backpressure)
//   m_valid/m_ready/m_data  rounded, decimated output stream
//   m_last                  marks the final sample of each frame
interface fir_out_frame_buf_if #(parameter int IN_W = 31, parameter int OUT_W = 16);
  logic din_valid;
  logic [IN_W-1:0] din;
  logic m_valid;
  logic m_ready;
  logic [OUT_W-1:0] m_data;
  logic m_last;
  modport master (output din_valid, din, m_ready, input m_valid, m_data, m_last);
  modport slave (input din_valid, din, m_ready, output m_valid, m_data, m_last);
endinterface

// File: rtl/fir_out_frame_buf.sv
// fir_out_frame_buf: round/saturate/decimate FIR output into a framed valid/ready FIFO stream
//   clk, rst (async, active high), en (low = soft clear of pipeline, FIFO and counters)
//   io        din_valid/din in, m_valid/m_ready/m_data/m_last out
//   ovf_sat   sticky: some sample was clamped
//   ovf_drop  sticky: some kept sample was lost to a full FIFO
//   fifo_lvl  current FIFO occupancy
module fir_out_frame_buf #(
  parameter int IN_W = 31,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEC = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  fir_out_frame_buf_if.slave io,
  output logic ovf_sat,
  output logic ovf_drop,
  output logic [$clog2(FIFO_DEPTH):0] fifo_lvl
);
  localparam int RW = IN_W + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = DEC > 1 ? $clog2(DEC) : 1;
  localparam int FW = $clog2(FRAME_LEN);
  localparam logic signed [RW-1:0] MAXV = RW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;
  logic signed [RW-1:0] r, s1_q;
  logic s1_valid, s1_keep, s2_valid, hi, lo, full, rd, wr, frame_end;
  logic [OUT_W-1:0] s2_data, sat_data;
  logic [PW-1:0] phase;
  logic [FW-1:0] frame_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [OUT_W:0] mem [FIFO_DEPTH];
  assign r = $signed({io.din[IN_W-1], io.din}) + RW'(2 ** (SHIFT - 1));
  assign hi = s1_q > MAXV;
  assign lo = s1_q < MINV;
  assign sat_data = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : s1_q[OUT_W-1:0];
  assign full = fifo_lvl == LW'(FIFO_DEPTH);
  assign io.m_valid = fifo_lvl != '0;
  assign rd = io.m_valid & io.m_ready;
  assign wr = s2_valid & (!full | rd);
  assign frame_end = frame_cnt == FW'(FRAME_LEN - 1);
  always_ff @(posedge clk)
    if (en & wr) mem[wr_ptr] <= {frame_end, s2_data};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_keep <= 1'b0;
      s1_q <= '0;
      s2_valid <= 1'b0;
      s2_data <= '0;
      phase <= '0;
      frame_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_lvl <= '0;
      ovf_sat <= 1'b0;
      ovf_drop <= 1'b0;
      io.m_data <= '0;
      io.m_last <= 1'b0;
    end else if (!en) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      phase <= '0;
      frame_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_lvl <= '0;
    end else begin
      s1_valid <= io.din_valid;
      s1_keep <= phase == '0;
      s1_q <= r >>> SHIFT;
      if (io.din_valid) phase <= phase == PW'(DEC - 1) ? '0 : phase + PW'(1);
      s2_valid <= s1_valid & s1_keep;
      s2_data <= sat_data;
      if (s1_valid & (hi | lo)) ovf_sat <= 1'b1;
      if (s2_valid & !wr) ovf_drop <= 1'b1;
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
        frame_cnt <= frame_end ? '0 : frame_cnt + FW'(1);
      end
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      fifo_lvl <= fifo_lvl + LW'(wr) - LW'(rd);
      // Registered head: the incoming write becomes head only if nothing older survives the pop
      if (wr || fifo_lvl > LW'(rd))
        {io.m_last, io.m_data} <= fifo_lvl == LW'(rd) ? {frame_end, s2_data} : mem[rd_ptr + AW'(rd)];
    end
endmodule

// File: tb/tb_fir_out_frame_buf.sv
// tb_fir_out_frame_buf: scoreboard bench over two configurations (DEC=1/FRAME 4/depth 16, DEC=4/FRAME 5/depth 4)
module tb_fir_out_frame_buf;
  typedef struct { int t; bit keep; bit sat; logic [15:0] d; } pend_t;
  logic clk = 0, rst = 0, en = 1, din_valid = 0;
  logic [30:0] din = '0;
  logic [1:0] rdy = 2'b11;
  bit rnd_rdy = 0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  task automatic chk(input int g, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d %s: got %0h expected %0h at %0t", g, nm, act, exp, $time);
    end
  endtask
  function automatic logic [16:0] rnd_sat(input logic [30:0] x);
    longint v, q;
    v = longint'($signed(x));
    q = longint'($floor((real'(v) + 16384.0) / 32768.0));
    if (q > 32767) return {1'b1, 16'h7fff};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int DEC = g == 0 ? 1 : 4;
    localparam int FL = g == 0 ? 4 : 5;
    localparam int DEPTH = g == 0 ? 16 : 4;
    fir_out_frame_buf_if io ();
    logic [$clog2(DEPTH):0] lvl_o;
    logic sat_o, drop_o;
    pend_t pend[$];
    logic [16:0] sb[$];
    logic [16:0] hold = '0;
    int lvl = 0, n_acc = 0, fc = 0, t = 0, clr = 0, clr_wi = 0, seen = 0, ri = 0;
    bit e_sat = 0, e_drop = 0, clr_hard = 0, pop, s;
    logic [15:0] d;
    assign io.din = din;
    assign io.din_valid = din_valid;
    assign io.m_ready = rdy[g];
    fir_out_frame_buf #(.DEC(DEC), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
      .clk(clk), .rst(rst), .en(en), .io(io),
      .ovf_sat(sat_o), .ovf_drop(drop_o), .fifo_lvl(lvl_o));
    // reference model: expected outputs are appended to sb as they enter the FIFO
    initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        pend.delete();
        lvl = 0; n_acc = 0; fc = 0; t = 0; e_sat = 0; e_drop = 0;
        clr_wi = sb.size(); clr_hard = 1; clr++;
      end else if (!en) begin
        pend.delete();
        lvl = 0; n_acc = 0; fc = 0;
        clr_wi = sb.size(); clr_hard = 0; clr++;
      end else begin
        pop = lvl != 0 && io.m_ready;
        foreach (pend[k]) if (pend[k].t + 1 == t && pend[k].sat) e_sat = 1;
        if (pend.size() != 0 && pend[0].t + 2 == t) begin
          if (pend[0].keep) begin
            if (lvl < DEPTH || pop) begin
              sb.push_back({fc == FL - 1, pend[0].d});
              fc = fc == FL - 1 ? 0 : fc + 1;
              lvl++;
            end else e_drop = 1;
          end
          void'(pend.pop_front());
        end
        if (pop) lvl--;
        if (din_valid) begin
          {s, d} = rnd_sat(din);
          pend.push_back('{t, n_acc % DEC == 0, s, d});
          n_acc++;
        end
        t++;
      end
    end
    // monitor: consumes scoreboard entries as the DUT presents them
    initial forever begin
      @(negedge clk);
      if (clr != seen) begin
        seen = clr;
        ri = clr_wi;
        if (clr_hard) hold = '0;
      end
      chk(g, "m_valid", io.m_valid, lvl != 0);
      chk(g, "fifo_lvl", lvl_o, lvl);
      chk(g, "ovf_sat", sat_o, e_sat);
      chk(g, "ovf_drop", drop_o, e_drop);
      if (io.m_valid) begin
        if (ri >= sb.size()) begin
          n_cmp++; n_bad++;
          $display("FAIL dut%0d unexpected_output: got %0h expected none at %0t", g, io.m_data, $time);
        end else begin
          chk(g, "m_data", io.m_data, sb[ri][15:0]);
          chk(g, "m_last", io.m_last, sb[ri][16]);
          hold = sb[ri];
          if (io.m_ready) ri++;
        end
      end else chk(g, "hold", {io.m_last, io.m_data}, hold);
    end
    initial forever begin
      @(posedge rst);
      #1 chk(g, "rst_zero", {io.m_valid, io.m_data, io.m_last, lvl_o, sat_o, drop_o}, '0);
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
    if (rnd_rdy) rdy = 2'($urandom);
  endtask
  task automatic idle(input int n);
    din_valid = 0;
    repeat (n) tick();
  endtask
  task automatic soft_clear();
    din_valid = 0;
    en = 0;
    tick();
    en = 1;
  endtask
  function automatic logic [30:0] rnd_din();
    int v;
    if ($urandom_range(0, 7) == 0) return 31'($urandom);
    v = int'($urandom_range(0, 2097152)) - 1048576;
    return 31'(v);
  endfunction
  initial begin
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    idle(2);
    din_valid = 1;
    foreach (din[i]) din[i] = 1'b0;
    din = 31'd16384; tick();
    din = 31'(-16385); tick();
    din = 31'(-16384); tick();
    idle(6);
    din_valid = 1;
    din = 31'h3fff_ffff; tick();
    din = 31'h4000_0000; tick();
    idle(6);
    soft_clear();
    din_valid = 1;
    for (int k = 1; k <= 8; k++) begin din = 31'(k << 15); tick(); end
    idle(8);
    soft_clear();
    din_valid = 1;
    for (int k = 0; k < 9; k++) begin din = rnd_din(); tick(); end
    idle(8);
    soft_clear();
    rdy = 2'b00;
    din_valid = 1;
    for (int k = 0; k < 20; k++) begin din = 31'((k + 1) << 15); tick(); end
    idle(4);
    rdy = 2'b11;
    idle(24);
    rnd_rdy = 1;
    for (int c = 0; c < 150; c++) begin
      din_valid = $urandom_range(0, 3) != 0;
      din = rnd_din();
      if (c == 60) en = 0;
      tick();
      en = 1;
      if (c == 100) begin rst = 1; #2 rst = 0; end
    end
    for (int c = 0; c < 250; c++) begin
      din_valid = $urandom_range(0, 3) != 0;
      din = rnd_din();
      en = $urandom_range(0, 49) != 0;
      tick();
    end
    en = 1;
    rnd_rdy = 0;
    rdy = 2'b11;
    idle(30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
